// File: rtl/lc3b_pkg.sv
// Shared LC-3b control definitions: opcodes, sequencer states, bus/mux
// select encodings and the per-state control word decode.
package lc3b_pkg;

   localparam int unsigned STATE_W = 5;
   localparam int unsigned OPC_W   = 4;

   localparam logic [OPC_W-1:0] OP_BR  = 4'b0000;
   localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
   localparam logic [OPC_W-1:0] OP_JSR = 4'b0100;
   localparam logic [OPC_W-1:0] OP_AND = 4'b0101;
   localparam logic [OPC_W-1:0] OP_LDW = 4'b0110;
   localparam logic [OPC_W-1:0] OP_STW = 4'b0111;
   localparam logic [OPC_W-1:0] OP_XOR = 4'b1001;
   localparam logic [OPC_W-1:0] OP_JMP = 4'b1100;
   localparam logic [OPC_W-1:0] OP_LEA = 4'b1110;

   typedef enum logic [STATE_W-1:0] {
      S_RST      = 5'd0,
      S_FETCH_A  = 5'd1,
      S_FETCH_B  = 5'd2,
      S_FETCH_C  = 5'd3,
      S_DECODE   = 5'd4,
      S_ALU_EX   = 5'd5,
      S_BR_EX    = 5'd6,
      S_JMP_EX   = 5'd7,
      S_JSR_A    = 5'd8,
      S_JSR_B    = 5'd9,
      S_LEA_EX   = 5'd10,
      S_MEM_ADDR = 5'd11,
      S_LD_RD    = 5'd12,
      S_LD_WB    = 5'd13,
      S_ST_MDR   = 5'd14,
      S_ST_WR    = 5'd15,
      S_ILLEGAL  = 5'd16,
      S_ERR      = 5'd17
   } state_t;

   typedef enum logic [2:0] {
      GATE_NONE   = 3'd0,
      GATE_PC     = 3'd1,
      GATE_ALU    = 3'd2,
      GATE_MDR    = 3'd3,
      GATE_MARMUX = 3'd4,
      GATE_SR1    = 3'd5
   } gate_sel_t;

   typedef enum logic [1:0] {
      PC_INC  = 2'd0,
      PC_BUS  = 2'd1,
      PC_ADDR = 2'd2
   } pc_sel_t;

   typedef enum logic [1:0] {
      A2_ZERO   = 2'd0,
      A2_SEXT6  = 2'd1,
      A2_SEXT9  = 2'd2,
      A2_SEXT11 = 2'd3
   } addr2_sel_t;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'd0,
      ALU_AND    = 2'd1,
      ALU_XOR    = 2'd2,
      ALU_PASS_A = 2'd3
   } alu_op_t;

   typedef struct packed {
      logic       mem_en;
      logic       mem_we;
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_pc;
      logic       ld_reg;
      logic       ld_cc;
      gate_sel_t  gate_sel;
      pc_sel_t    pc_sel;
      logic       addr1_sel;
      addr2_sel_t addr2_sel;
      alu_op_t    alu_op;
      logic       alu_imm;
      logic       dr_sel;
      logic       illegal;
      logic       bus_err;
   } ctrl_t;

   // Control word asserted while the sequencer sits in state s.
   function automatic ctrl_t ctrl_for(state_t s, logic [OPC_W-1:0] op,
                                      logic ir11, logic ir5, logic ben);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH_A: begin
            c.gate_sel = GATE_PC;
            c.ld_mar   = 1'b1;
            c.ld_pc    = 1'b1;
            c.pc_sel   = PC_INC;
         end
         S_FETCH_B, S_LD_RD: begin
            c.mem_en = 1'b1;
            c.ld_mdr = 1'b1;
         end
         S_FETCH_C: begin
            c.gate_sel = GATE_MDR;
            c.ld_ir    = 1'b1;
         end
         S_ALU_EX: begin
            c.gate_sel = GATE_ALU;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
            c.alu_imm  = ir5;
            case (op)
               OP_AND:  c.alu_op = ALU_AND;
               OP_XOR:  c.alu_op = ALU_XOR;
               default: c.alu_op = ALU_ADD;
            endcase
         end
         S_BR_EX: begin
            if (ben) begin
               c.addr1_sel = 1'b0;
               c.addr2_sel = A2_SEXT9;
               c.pc_sel    = PC_ADDR;
               c.ld_pc     = 1'b1;
            end
         end
         S_JMP_EX: begin
            c.gate_sel = GATE_SR1;
            c.pc_sel   = PC_BUS;
            c.ld_pc    = 1'b1;
         end
         S_JSR_A: begin
            c.gate_sel = GATE_PC;
            c.dr_sel   = 1'b1;
            c.ld_reg   = 1'b1;
         end
         S_JSR_B: begin
            if (ir11) begin
               c.addr2_sel = A2_SEXT11;
               c.pc_sel    = PC_ADDR;
            end else begin
               c.gate_sel = GATE_SR1;
               c.pc_sel   = PC_BUS;
            end
            c.ld_pc = 1'b1;
         end
         S_LEA_EX: begin
            c.addr2_sel = A2_SEXT9;
            c.gate_sel  = GATE_MARMUX;
            c.ld_reg    = 1'b1;
         end
         S_MEM_ADDR: begin
            c.addr1_sel = 1'b1;
            c.addr2_sel = A2_SEXT6;
            c.gate_sel  = GATE_MARMUX;
            c.ld_mar    = 1'b1;
         end
         S_LD_WB: begin
            c.gate_sel = GATE_MDR;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
         end
         S_ST_MDR: begin
            c.gate_sel = GATE_SR1;
            c.ld_mdr   = 1'b1;
         end
         S_ST_WR: begin
            c.mem_en = 1'b1;
            c.mem_we = 1'b1;
         end
         S_ILLEGAL: c.illegal = 1'b1;
         S_ERR:     c.bus_err = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lc3b_ctrl_seq_if.sv
// Memory handshake between the control sequencer and the memory port.
//   mem_en    : access request (sequencer -> memory)
//   mem_we    : 1 = write, 0 = read, valid with mem_en
//   mem_ready : access completes this cycle (memory -> sequencer)
interface lc3b_ctrl_seq_if;
   logic mem_en;
   logic mem_we;
   logic mem_ready;

   modport master (output mem_en, output mem_we, input mem_ready);
   modport slave  (input mem_en, input mem_we, output mem_ready);
endinterface

// File: rtl/lc3b_wait_timer.sv
// Memory wait-state watchdog.
//   clk_50, rst_n : clock, async active-low reset
//   clr           : hold count at zero (sequencer outside a wait state)
//   en            : a wait cycle with mem_ready low
//   expired_c     : this not-ready cycle is the WAIT_LIMIT-th in a row
module lc3b_wait_timer #(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned WAIT_W     = 4
) (
   input  logic clk_50,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired_c
);

   logic [WAIT_W-1:0] cnt_q;

   // Counts not-ready cycles already spent in the current wait state.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + WAIT_W'(1);
      end
   end

   assign expired_c = en && (cnt_q == WAIT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/lc3b_ctrl_seq.sv
// LC-3b multi-cycle control sequencer (Moore). Fetches, decodes and executes
// BR/ADD/AND/XOR/JMP/JSR(R)/LDW/STW/LEA, with a watchdog on memory waits.
//   clk_50, rst_n       : clock, async active-low reset
//   ir, cc              : instruction register, condition codes {n,z,p}
//   mem                 : memory handshake (mem_en/mem_we out, mem_ready in)
//   ld_*                : register load enables
//   gate_sel, pc_sel,
//   addr1_sel, addr2_sel,
//   alu_op, alu_imm,
//   dr_sel              : datapath steering
//   illegal, bus_err    : one-cycle fault pulses
//   state               : current state (debug)
module lc3b_ctrl_seq
   import lc3b_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 15,
   parameter int unsigned WAIT_W     = 4
) (
   input  logic                 clk_50,
   input  logic                 rst_n,
   input  logic [15:0]          ir,
   input  logic [2:0]           cc,
   lc3b_ctrl_seq_if.master      mem,
   output logic                 ld_mar,
   output logic                 ld_mdr,
   output logic                 ld_ir,
   output logic                 ld_pc,
   output logic                 ld_reg,
   output logic                 ld_cc,
   output logic [2:0]           gate_sel,
   output logic [1:0]           pc_sel,
   output logic                 addr1_sel,
   output logic [1:0]           addr2_sel,
   output logic [1:0]           alu_op,
   output logic                 alu_imm,
   output logic                 dr_sel,
   output logic                 illegal,
   output logic                 bus_err,
   output logic [STATE_W-1:0]   state
);

   state_t            state_q;
   state_t            state_d;
   ctrl_t             ctrl_q;
   ctrl_t             ctrl_d;
   logic [OPC_W-1:0]  op;
   logic              ben_c;
   logic              in_wait_c;
   logic              expired_c;
   logic              unused_ir;

   assign op        = ir[15:12];
   assign ben_c     = |(ir[11:9] & cc);
   assign in_wait_c = (state_q == S_FETCH_B) || (state_q == S_LD_RD) ||
                      (state_q == S_ST_WR);
   assign unused_ir = ^{ir[8:6], ir[4:0]};

   lc3b_wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .WAIT_W     (WAIT_W)
   ) u_wait_timer (
      .clk_50    (clk_50),
      .rst_n     (rst_n),
      .clr       (!in_wait_c),
      .en        (in_wait_c && !mem.mem_ready),
      .expired_c (expired_c)
   );

   // Next state; mem_ready wins over an expiring watchdog in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:     state_d = S_FETCH_A;
         S_FETCH_A: state_d = S_FETCH_B;
         S_FETCH_B: begin
            if (mem.mem_ready)  state_d = S_FETCH_C;
            else if (expired_c) state_d = S_ERR;
         end
         S_FETCH_C: state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_ADD, OP_AND, OP_XOR: state_d = S_ALU_EX;
               OP_BR:                  state_d = S_BR_EX;
               OP_JMP:                 state_d = S_JMP_EX;
               OP_JSR:                 state_d = S_JSR_A;
               OP_LDW, OP_STW:         state_d = S_MEM_ADDR;
               OP_LEA:                 state_d = S_LEA_EX;
               default:                state_d = S_ILLEGAL;
            endcase
         end
         S_JSR_A:    state_d = S_JSR_B;
         S_MEM_ADDR: state_d = (op == OP_LDW) ? S_LD_RD : S_ST_MDR;
         S_LD_RD: begin
            if (mem.mem_ready)  state_d = S_LD_WB;
            else if (expired_c) state_d = S_ERR;
         end
         S_ST_MDR: state_d = S_ST_WR;
         S_ST_WR: begin
            if (mem.mem_ready)  state_d = S_FETCH_A;
            else if (expired_c) state_d = S_ERR;
         end
         S_ALU_EX, S_BR_EX, S_JMP_EX, S_JSR_B, S_LEA_EX, S_LD_WB,
         S_ILLEGAL, S_ERR:  state_d = S_FETCH_A;
         default:           state_d = S_RST;
      endcase
   end

   // Control word is decoded for the state being entered so it lands
   // registered in the same cycle as that state.
   always_comb begin
      ctrl_d = ctrl_for(state_d, op, ir[11], ir[5], ben_c);
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RST;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign mem.mem_en = ctrl_q.mem_en;
   assign mem.mem_we = ctrl_q.mem_we;
   assign ld_mar     = ctrl_q.ld_mar;
   assign ld_mdr     = ctrl_q.ld_mdr;
   assign ld_ir      = ctrl_q.ld_ir;
   assign ld_pc      = ctrl_q.ld_pc;
   assign ld_reg     = ctrl_q.ld_reg;
   assign ld_cc      = ctrl_q.ld_cc;
   assign gate_sel   = ctrl_q.gate_sel;
   assign pc_sel     = ctrl_q.pc_sel;
   assign addr1_sel  = ctrl_q.addr1_sel;
   assign addr2_sel  = ctrl_q.addr2_sel;
   assign alu_op     = ctrl_q.alu_op;
   assign alu_imm    = ctrl_q.alu_imm;
   assign dr_sel     = ctrl_q.dr_sel;
   assign illegal    = ctrl_q.illegal;
   assign bus_err    = ctrl_q.bus_err;
   assign state      = state_q;

endmodule

// File: tb/tb_lc3b_ctrl_seq.sv
// Bench for lc3b_ctrl_seq: builds the expected per-cycle state/control trace
// of each instruction from the instruction-level rules, then compares it
// cycle by cycle (sampled on the falling edge).
module tb_lc3b_ctrl_seq;
   import lc3b_pkg::*;

   localparam int unsigned LIMIT = 15;

   typedef struct packed {
      logic       mem_en;
      logic       mem_we;
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_pc;
      logic       ld_reg;
      logic       ld_cc;
      logic [2:0] gate;
      logic [1:0] pc_sel;
      logic       addr1;
      logic [1:0] addr2;
      logic [1:0] alu_op;
      logic       alu_imm;
      logic       dr_sel;
      logic       illegal;
      logic       bus_err;
   } exp_t;

   logic        clk_50;
   logic        rst_n;
   logic [15:0] ir;
   logic [2:0]  cc;
   logic        ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
   logic [2:0]  gate_sel;
   logic [1:0]  pc_sel;
   logic        addr1_sel;
   logic [1:0]  addr2_sel;
   logic [1:0]  alu_op;
   logic        alu_imm, dr_sel, illegal, bus_err;
   logic [4:0]  state;

   int n_checks = 0;
   int n_fail   = 0;

   state_t q_st[$];
   exp_t   q_o[$];
   bit     q_rdy[$];

   lc3b_ctrl_seq_if mem_if ();

   lc3b_ctrl_seq #(.WAIT_LIMIT(15), .WAIT_W(4)) dut (
      .clk_50    (clk_50),
      .rst_n     (rst_n),
      .ir        (ir),
      .cc        (cc),
      .mem       (mem_if),
      .ld_mar    (ld_mar),
      .ld_mdr    (ld_mdr),
      .ld_ir     (ld_ir),
      .ld_pc     (ld_pc),
      .ld_reg    (ld_reg),
      .ld_cc     (ld_cc),
      .gate_sel  (gate_sel),
      .pc_sel    (pc_sel),
      .addr1_sel (addr1_sel),
      .addr2_sel (addr2_sel),
      .alu_op    (alu_op),
      .alu_imm   (alu_imm),
      .dr_sel    (dr_sel),
      .illegal   (illegal),
      .bus_err   (bus_err),
      .state     (state)
   );

   initial clk_50 = 1'b0;
   always #5 clk_50 = ~clk_50;

   function automatic exp_t obs();
      return exp_t'({mem_if.mem_en, mem_if.mem_we, ld_mar, ld_mdr, ld_ir,
                     ld_pc, ld_reg, ld_cc, gate_sel, pc_sel, addr1_sel,
                     addr2_sel, alu_op, alu_imm, dr_sel, illegal, bus_err});
   endfunction

   function automatic bit rnd();
      return 1'($urandom);
   endfunction

   function automatic void push(state_t st, exp_t o, bit rdy);
      q_st.push_back(st);
      q_o.push_back(o);
      q_rdy.push_back(rdy);
   endfunction

   // A wait of d not-ready cycles; returns 1 if it aborts to ERR.
   function automatic bit add_wait(state_t st, exp_t o, int d);
      int   n;
      exp_t e;
      n = (d >= int'(LIMIT)) ? int'(LIMIT) : d + 1;
      for (int i = 0; i < n; i++)
         push(st, o, (i == n - 1) && (d < int'(LIMIT)));
      if (d >= int'(LIMIT)) begin
         e = '0;
         e.bus_err = 1'b1;
         push(S_ERR, e, rnd());
         return 1'b1;
      end
      return 1'b0;
   endfunction

   // Expected trace of one instruction starting in FETCH_A.
   function automatic void build(logic [15:0] i, logic [2:0] c, int df, int dm);
      exp_t       e;
      logic [3:0] op;
      op = i[15:12];
      e = '0; e.gate = 3'd1; e.ld_mar = 1'b1; e.ld_pc = 1'b1;
      push(S_FETCH_A, e, rnd());
      e = '0; e.mem_en = 1'b1; e.ld_mdr = 1'b1;
      if (add_wait(S_FETCH_B, e, df)) return;
      e = '0; e.gate = 3'd3; e.ld_ir = 1'b1;
      push(S_FETCH_C, e, rnd());
      e = '0;
      push(S_DECODE, e, rnd());
      e = '0;
      case (op)
         4'h1, 4'h5, 4'h9: begin
            e.gate = 3'd2; e.ld_reg = 1'b1; e.ld_cc = 1'b1; e.alu_imm = i[5];
            e.alu_op = (op == 4'h5) ? 2'd1 : (op == 4'h9) ? 2'd2 : 2'd0;
            push(S_ALU_EX, e, rnd());
         end
         4'h0: begin
            if ((i[11] && c[2]) || (i[10] && c[1]) || (i[9] && c[0])) begin
               e.addr2 = 2'd2; e.pc_sel = 2'd2; e.ld_pc = 1'b1;
            end
            push(S_BR_EX, e, rnd());
         end
         4'hC: begin
            e.gate = 3'd5; e.pc_sel = 2'd1; e.ld_pc = 1'b1;
            push(S_JMP_EX, e, rnd());
         end
         4'h4: begin
            e.gate = 3'd1; e.dr_sel = 1'b1; e.ld_reg = 1'b1;
            push(S_JSR_A, e, rnd());
            e = '0;
            if (i[11]) begin e.addr2 = 2'd3; e.pc_sel = 2'd2; end
            else begin e.gate = 3'd5; e.pc_sel = 2'd1; end
            e.ld_pc = 1'b1;
            push(S_JSR_B, e, rnd());
         end
         4'hE: begin
            e.addr2 = 2'd2; e.gate = 3'd4; e.ld_reg = 1'b1;
            push(S_LEA_EX, e, rnd());
         end
         4'h6, 4'h7: begin
            e.addr1 = 1'b1; e.addr2 = 2'd1; e.gate = 3'd4; e.ld_mar = 1'b1;
            push(S_MEM_ADDR, e, rnd());
            e = '0;
            if (op == 4'h6) begin
               e.mem_en = 1'b1; e.ld_mdr = 1'b1;
               if (add_wait(S_LD_RD, e, dm)) return;
               e = '0; e.gate = 3'd3; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
               push(S_LD_WB, e, rnd());
            end else begin
               e.gate = 3'd5; e.ld_mdr = 1'b1;
               push(S_ST_MDR, e, rnd());
               e = '0; e.mem_en = 1'b1; e.mem_we = 1'b1;
               void'(add_wait(S_ST_WR, e, dm));
            end
         end
         default: begin
            e.illegal = 1'b1;
            push(S_ILLEGAL, e, rnd());
         end
      endcase
   endfunction

   task automatic check(string tag, state_t st, exp_t o);
      exp_t got;
      got = obs();
      n_checks++;
      assert (state === st) else begin
         n_fail++;
         $error("FAIL %s state: observed %0d expected %0d", tag, state, st);
      end
      n_checks++;
      assert (got === o) else begin
         n_fail++;
         $error("FAIL %s ctrl: observed %h expected %h", tag, got, o);
      end
   endtask

   task automatic run(string tag, logic [15:0] i, logic [2:0] c, int df, int dm);
      q_st.delete(); q_o.delete(); q_rdy.delete();
      build(i, c, df, dm);
      ir = i;
      cc = c;
      for (int k = 0; k < q_st.size(); k++) begin
         check($sformatf("%s.%0d", tag, k), q_st[k], q_o[k]);
         mem_if.mem_ready = q_rdy[k];
         @(negedge clk_50);
      end
      mem_if.mem_ready = 1'b0;
   endtask

   initial begin
      exp_t        z;
      exp_t        e;
      logic [15:0] ri;
      logic [3:0]  rop;
      int          df, dm;
      z = '0;
      rst_n = 1'b0;
      ir = 16'h0000;
      cc = 3'b000;
      mem_if.mem_ready = 1'b0;

      // Power-on reset.
      repeat (2) @(negedge clk_50);
      check("por", S_RST, z);
      rst_n = 1'b1;
      check("por_rel", S_RST, z);
      @(negedge clk_50);

      // Reset asserted in the middle of a fetch wait.
      e = '0; e.gate = 3'd1; e.ld_mar = 1'b1; e.ld_pc = 1'b1;
      check("pre_fa", S_FETCH_A, e);
      @(negedge clk_50);
      e = '0; e.mem_en = 1'b1; e.ld_mdr = 1'b1;
      check("pre_fb", S_FETCH_B, e);
      #2 rst_n = 1'b0;
      #1 check("rst_mid", S_RST, z);
      @(negedge clk_50);
      check("rst_hold", S_RST, z);
      rst_n = 1'b1;
      @(negedge clk_50);

      // Directed instructions.
      run("add_imm",  16'h1261, 3'b000, 3, 0);
      run("br_nt",    16'h0A05, 3'b010, 0, 0);
      run("br_tk",    16'h0A05, 3'b100, 0, 0);
      run("br_000",   16'h0005, 3'b111, 0, 0);
      run("ldw",      16'h6283, 3'b000, 0, 0);
      run("stw_to",   16'h7283, 3'b000, 0, 16);
      run("illegal",  16'hA000, 3'b000, 0, 0);
      run("not",      16'h967F, 3'b001, 0, 0);
      run("and_reg",  16'h5042, 3'b001, 1, 0);
      run("jmp",      16'hC1C0, 3'b001, 0, 0);
      run("jsr",      16'h4805, 3'b001, 0, 0);
      run("jsrr",     16'h4080, 3'b001, 0, 0);
      run("lea",      16'hE3FF, 3'b001, 0, 0);
      run("ldw_lim",  16'h6283, 3'b010, 0, 14);
      run("ldw_to",   16'h6283, 3'b010, 2, 15);
      run("stw_lim",  16'h7283, 3'b010, 0, 14);
      run("fetch_to", 16'h1261, 3'b010, 15, 0);

      // Random instruction stream.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 9))
            0: rop = 4'h0;  1: rop = 4'h1;  2: rop = 4'h5;
            3: rop = 4'h9;  4: rop = 4'hC;  5: rop = 4'h4;
            6: rop = 4'h6;  7: rop = 4'h7;  8: rop = 4'hE;
            default: rop = 4'($urandom);
         endcase
         ri = {rop, 12'($urandom)};
         df = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 16))
                                          : int'($urandom_range(0, 3));
         dm = ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 16))
                                          : int'($urandom_range(0, 3));
         run($sformatf("rnd%0d", n), ri, 3'($urandom), df, dm);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
